// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin burst-locked N:1 stream mux with registered output
module rr_mux_arbiter #(
    parameter int LOG2_N = 2,
    parameter int WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [(1<<LOG2_N)-1:0]            s_valid,
    input  logic [(1<<LOG2_N)*WIDTH-1:0]      s_data,
    input  logic [(1<<LOG2_N)-1:0]            s_last,
    output logic [(1<<LOG2_N)-1:0]            s_ready,
    output logic                              m_valid,
    output logic [WIDTH-1:0]                  m_data,
    output logic                              m_last,
    output logic [LOG2_N-1:0]                 m_src,
    input  logic                              m_ready
);
    localparam int N = 1 << LOG2_N;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LOG2_N-1:0]   ptr_q, ptr_d;
    logic [LOG2_N-1:0]   g_q, g_d;
    logic                m_valid_q, m_valid_d;
    logic [WIDTH-1:0]    m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic [LOG2_N-1:0]   m_src_q, m_src_d;

    logic [N-1:0]        s_ready_c;
    logic                found;
    logic [LOG2_N-1:0]   pick;
    logic [LOG2_N-1:0]   idx;
    logic                xfer;

    // Cyclic scan from ptr, grant/accept logic and output-register next state
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_src_d   = m_src_q;
        s_ready_c = '0;
        found     = 1'b0;
        pick      = '0;
        idx       = '0;
        xfer      = 1'b0;

        // Index arithmetic wraps naturally at N because idx is LOG2_N bits wide
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + LOG2_N'(k);
            if (!found && s_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    g_d     = pick;
                end
            end
            BUSY: begin
                s_ready_c[g_q] = !m_valid_q || m_ready;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // No source may be accepted while reset is asserted
        if (reset) begin
            s_ready_c = '0;
        end

        xfer = s_valid[g_q] && s_ready_c[g_q];

        if (xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data[int'(g_q)*WIDTH +: WIDTH];
            m_last_d  = s_last[g_q];
            m_src_d   = g_q;
            if (s_last[g_q]) begin
                ptr_d   = g_q + LOG2_N'(1);
                state_d = IDLE;
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State, pointer, grant and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_src_q   <= m_src_d;
        end
    end

    assign s_ready = s_ready_c;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_src   = m_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
    localparam int LOG2_N = 2;
    localparam int N      = 4;
    localparam int WIDTH  = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       s_valid;
    logic [N*WIDTH-1:0] s_data;
    logic [N-1:0]       s_last;
    logic [N-1:0]       s_ready;
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic               m_last;
    logic [LOG2_N-1:0]  m_src;
    logic               m_ready = 1'b1;

    rr_mux_arbiter #(.LOG2_N(LOG2_N), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_src   (m_src),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOG2_N-1:0] src;
        logic              last;
        logic [WIDTH-1:0]  data;
        int                gap;
    } exp_t;

    exp_t       expq[$];
    logic [9:0] rq[N][$];   // [9]=bubble, [8]=last, [7:0]=data
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;
    int         last_beat = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push_beat(input int i, input logic [7:0] d, input logic l);
        rq[i].push_back({1'b0, l, d});
    endtask

    task automatic push_bubble(input int i);
        rq[i].push_back(10'h200);
    endtask

    task automatic expect_beat(input logic [LOG2_N-1:0] s, input logic [7:0] d, input logic l, input int gap);
        exp_t e;
        e.src = s; e.data = d; e.last = l; e.gap = gap;
        expq.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() + expq.size()) != 0
                || m_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(name, (t < 300), 1);
    endtask

    task automatic wait_mvalid(input string name);
        int t = 0;
        while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(name, (t < 50), 1);
    endtask

    // Requester driver: present queue heads, retire them on handshake
    initial begin
        logic [N-1:0] fire;
        logic [N-1:0] shown;
        logic         rst_seen;
        logic [9:0]   tmp;
        s_valid = '0; s_data = '0; s_last = '0; shown = '0;
        forever begin
            @(negedge clk);
            fire     = s_valid & s_ready;
            rst_seen = reset;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst_seen) begin
                    rq[i].delete();
                end else if (shown[i] && (fire[i] || rq[i][0][9])) begin
                    tmp = rq[i].pop_front();
                end
                shown[i] = 1'b0;
                if (rq[i].size() != 0) begin
                    shown[i]   = 1'b1;
                    s_valid[i] = !rq[i][0][9];
                    s_last[i]  = rq[i][0][8];
                    s_data[i*WIDTH +: WIDTH] = rq[i][0][7:0];
                end else begin
                    s_valid[i] = 1'b0;
                    s_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every downstream transfer against the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            check("s_ready_onehot", ($countones(s_ready) <= 1), 1);
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got src=%0d data=%0h expected none", m_src, m_data);
                end else begin
                    e = expq.pop_front();
                    check("beat", {m_src, m_last, m_data}, {e.src, e.last, e.data});
                    if (e.gap != 0) check("beat_gap", cycle - last_beat, e.gap);
                end
                last_beat = cycle;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_src", m_src, 0);
        check("rst_s_ready", s_ready, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 0);
        check("post_rst_m_valid", m_valid, 0);

        // Single requester, minimum latency
        push_beat(2, 8'h0c, 1'b1);
        expect_beat(2, 8'h0c, 1'b1, 0);
        begin
            int t = 0;
            while (!s_valid[2] && t < 20) begin @(negedge clk); t++; end
            check("t1_svalid_seen", (t < 20), 1);
        end
        check("t1_cyc0_s_ready", s_ready, 4'b0000);
        @(negedge clk);
        check("t1_cyc1_s_ready", s_ready, 4'b0100);
        check("t1_cyc1_m_valid", m_valid, 0);
        @(negedge clk);
        check("t1_cyc2_m_valid", m_valid, 1);
        wait_idle("t1_idle");

        // ptr is 3 now: requesters 1 and 3 together -> 3 first
        push_beat(1, 8'h11, 1'b1);
        push_beat(3, 8'h33, 1'b1);
        expect_beat(3, 8'h33, 1'b1, 0);
        expect_beat(1, 8'h11, 1'b1, 2);
        wait_idle("t1b_idle");

        // Round robin over all four from ptr 0, wrapping back to 0
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        push_beat(0, 8'h0d, 1'b1);
        push_beat(0, 8'h0e, 1'b1);
        push_beat(1, 8'h0c, 1'b1);
        push_beat(2, 8'h0b, 1'b1);
        push_beat(3, 8'h0a, 1'b1);
        expect_beat(0, 8'h0d, 1'b1, 0);
        expect_beat(1, 8'h0c, 1'b1, 2);
        expect_beat(2, 8'h0b, 1'b1, 2);
        expect_beat(3, 8'h0a, 1'b1, 2);
        expect_beat(0, 8'h0e, 1'b1, 2);
        wait_idle("t2_idle");

        // Burst lock (ptr 1): requester 1 drops valid mid-burst, 0 waits
        push_beat(1, 8'h21, 1'b0);
        push_bubble(1);
        push_beat(1, 8'h22, 1'b0);
        push_beat(1, 8'h23, 1'b1);
        push_beat(0, 8'h30, 1'b1);
        expect_beat(1, 8'h21, 1'b0, 0);
        expect_beat(1, 8'h22, 1'b0, 0);
        expect_beat(1, 8'h23, 1'b1, 0);
        expect_beat(0, 8'h30, 1'b1, 0);
        wait_idle("t3_idle");

        // Backpressure (ptr 1): requester 2 granted
        m_ready = 1'b0;
        push_beat(2, 8'h40, 1'b0);
        push_beat(2, 8'h41, 1'b0);
        push_beat(2, 8'h42, 1'b1);
        expect_beat(2, 8'h40, 1'b0, 0);
        expect_beat(2, 8'h41, 1'b0, 0);
        expect_beat(2, 8'h42, 1'b1, 0);
        wait_mvalid("t4_mvalid");
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_data", m_data, 8'h40);
            check("t4_hold_s_ready", s_ready, 4'b0000);
            @(negedge clk);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_reload_m_valid", m_valid, 1);
        check("t4_reload_data", m_data, 8'h41);
        wait_idle("t4_idle");

        // Reset mid-burst with a pending beat (ptr 3)
        m_ready = 1'b0;
        push_beat(1, 8'h50, 1'b0);
        push_beat(1, 8'h51, 1'b0);
        push_beat(1, 8'h52, 1'b1);
        wait_mvalid("t5_mvalid");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("t5_during_rst_s_ready", s_ready, 4'b0000);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t5_m_valid", m_valid, 0);
        check("t5_s_ready", s_ready, 4'b0000);
        check("t5_m_data", m_data, 0);
        m_ready = 1'b1;
        push_beat(3, 8'h63, 1'b1);
        push_beat(0, 8'h60, 1'b1);
        expect_beat(0, 8'h60, 1'b1, 0);
        expect_beat(3, 8'h63, 1'b1, 2);
        wait_idle("t5_idle");

        check("scoreboard_empty", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter LOG2_N, default 2, meaning log2 of requester count; N = 1<<LOG2_N.
REQ-002 SHALL have parameter WIDTH, default 8, meaning data bits per requester beat.
REQ-003 SHALL use one clock and a synchronous, active-high reset; clock port clk, reset port reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port s_valid  input  N  per-requester beat valid; bit i = requester i.
REQ-007 SHALL have port s_data  input  N*WIDTH  packed requester data; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port s_last  input  N  per-requester end-of-burst flag, qualified by s_valid.
REQ-009 SHALL have port s_ready  output  N  per-requester beat accept; at most one bit high.
REQ-010 SHALL have port m_valid  output  1  output register holds a beat.
REQ-011 SHALL have port m_data  output  WIDTH  registered selected beat.
REQ-012 SHALL have port m_last  output  1  registered s_last of the beat.
REQ-013 SHALL have port m_src  output  LOG2_N  index of the requester that sourced the beat.
REQ-014 SHALL have port m_ready  input  1  downstream accept; beat transfers when m_valid && m_ready.

Function
REQ-015 SHALL implement two states: IDLE (no grant) and BUSY (grant held by index g).
REQ-016 IDLE: if any s_valid bit is set, SHALL move to BUSY next cycle with g = first i with s_valid[i], scanning cyclically from ptr (ptr, ptr+1, ... N-1, 0, ...).
REQ-017 IDLE: s_ready SHALL be all zero; arbitration costs exactly one cycle.
REQ-018 BUSY: s_ready[g] SHALL equal (!m_valid || m_ready); all other s_ready bits zero.
REQ-019 A source beat SHALL transfer when s_valid[g] && s_ready[g]; next cycle m_data = s_data slice g, m_last = s_last[g], m_src = g, m_valid = 1.
REQ-020 Output register SHALL behave as a single-entry pipeline: m_ready with a simultaneous source transfer reloads it and keeps m_valid = 1; m_ready without a transfer clears m_valid.
REQ-021 m_data/m_last/m_src SHALL hold stable while m_valid && !m_ready.
REQ-022 Transfer with s_last[g] = 1 SHALL set ptr <= (g+1) mod N (wrap N-1 -> 0) and return to IDLE next cycle.
REQ-023 Grant SHALL remain locked to g across a burst even when s_valid[g] drops mid-burst; no timeout, no preemption.
REQ-024 ptr SHALL change only on a last-beat transfer.
REQ-025 Data path SHALL select s_data slice g as an N:1 mux of WIDTH bits; no arithmetic on data.
REQ-026 Minimum latency: s_valid rise in IDLE at cycle 0 -> s_ready at cycle 1 -> m_valid at cycle 2.

Reset
REQ-027 reset SHALL force, on the next rising edge: state IDLE, ptr 0, g 0, m_valid 0, m_data 0, m_last 0, m_src 0.
REQ-028 reset SHALL dominate all other inputs, including mid-burst and with a pending output beat; the pending beat is discarded.
REQ-029 s_ready SHALL be all zero during and in the cycle after reset.

Verification
REQ-030 Single requester: LOG2_N=2, WIDTH=8, s_valid=4'b0100, s_data slice2=8'h0c, s_last[2]=1, m_ready=1 -> s_ready=4'b0100 at cycle 1, m_valid=1, m_data=8'h0c, m_src=2, m_last=1 at cycle 2, IDLE with ptr=3 after.
REQ-031 All four requesting single-beat bursts (data 8'h0d,8'h0c,8'h0b,8'h0a for i=0..3), m_ready=1 -> m_src sequence 0,1,2,3,0 with one idle cycle between grants; ptr wraps 3 -> 0.
REQ-032 Burst lock: requester 1 sends 3 beats (last on third) while requester 0 holds s_valid -> m_src=1 for all three beats, then requester 0 granted.
REQ-033 Backpressure: m_ready=0 for 5 cycles with m_valid=1 -> m_data stable, s_ready all zero; m_ready=1 -> beat drains, next beat loads same cycle with m_valid staying 1.
REQ-034 Reset mid-burst: assert reset after 1 of 3 beats with m_valid=1 -> next cycle m_valid=0, s_ready=0, ptr=0; requester 3 and 0 then request -> requester 0 granted first.
